// File: rtl/brtag_alloc.sv
// brtag_alloc: one-hot branch-tag allocator tracking live tags, retiring on resolve and
// killing younger tags on mispredict. Define BRTAG_STATS_EN to add allocation/kill counters.
module brtag_alloc #(
  parameter int WIDTH_BRM = 4,
  parameter int WIDTH_CNT = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_alloc,
  output logic                 o_ready,
  output logic [WIDTH_BRM-1:0] o_tag,
  output logic [WIDTH_BRM-1:0] o_brmask,
  input  logic                 i_res_valid,
  input  logic [WIDTH_BRM-1:0] i_res_tag,
  input  logic                 i_res_kill,
  output logic [WIDTH_BRM-1:0] o_kill_mask,
  output logic [WIDTH_BRM-1:0] o_free_mask,
  output logic                 o_full,
  output logic                 o_empty
`ifdef BRTAG_STATS_EN
  ,
  output logic [WIDTH_CNT-1:0] o_alloc_cnt,
  output logic [WIDTH_CNT-1:0] o_kill_cnt
`endif
);

  localparam logic [WIDTH_BRM-1:0] ZERO_BRM = {WIDTH_BRM{1'b0}};
  localparam logic [WIDTH_BRM-1:0] ONE_BRM  = {{(WIDTH_BRM-1){1'b0}}, 1'b1};

  function automatic logic is_onehot(input logic [WIDTH_BRM-1:0] v);
    return (v != ZERO_BRM) && ((v & (v - ONE_BRM)) == ZERO_BRM);
  endfunction

  logic [WIDTH_BRM-1:0]                live_q, live_d;
  logic [WIDTH_BRM-1:0][WIDTH_BRM-1:0] dep_q, dep_d;
  logic [WIDTH_BRM-1:0]                kill_q, kill_d;
  logic [WIDTH_BRM-1:0]                free_q, free_d;

  logic [WIDTH_BRM-1:0] free_list_s;
  logic [WIDTH_BRM-1:0] tag_s;
  logic [WIDTH_BRM-1:0] kill_set_s;
  logic [WIDTH_BRM-1:0] clr_s;
  logic                 ready_s;
  logic                 res_live_s;
  logic                 free_fire_s;
  logic                 kill_fire_s;
  logic                 alloc_fire_s;

  // Free list and lowest-free tag come from registered state only, so a tag freed
  // this cycle is not handed out until the next one.
  always_comb begin
    free_list_s  = ~live_q;
    tag_s        = free_list_s & (~free_list_s + ONE_BRM);
    ready_s      = (free_list_s != ZERO_BRM);
    res_live_s   = is_onehot(i_res_tag) && ((i_res_tag & live_q) != ZERO_BRM);
    free_fire_s  = i_res_valid && !i_res_kill && res_live_s;
    kill_fire_s  = i_res_valid && i_res_kill && res_live_s;
    alloc_fire_s = i_alloc && ready_s && !kill_fire_s;
  end

  // A live tag dies with tag k when k was live at its allocation, i.e. it is younger.
  always_comb begin
    kill_set_s = ZERO_BRM;
    for (int j = 0; j < WIDTH_BRM; j++) begin
      kill_set_s[j] = i_res_tag[j] | (live_q[j] & ((dep_q[j] & i_res_tag) != ZERO_BRM));
    end
  end

  // Next-state for live set, dependency rows and broadcast pulses.
  always_comb begin
    if (free_fire_s) begin
      clr_s = i_res_tag;
    end else if (kill_fire_s) begin
      clr_s = kill_set_s;
    end else begin
      clr_s = ZERO_BRM;
    end
    live_d = (live_q & ~clr_s) | (alloc_fire_s ? tag_s : ZERO_BRM);
    kill_d = kill_fire_s ? kill_set_s : ZERO_BRM;
    free_d = free_fire_s ? i_res_tag : ZERO_BRM;
    dep_d  = dep_q;
    for (int j = 0; j < WIDTH_BRM; j++) begin
      if (kill_fire_s && kill_set_s[j]) begin
        dep_d[j] = ZERO_BRM;
      end else if (alloc_fire_s && tag_s[j]) begin
        dep_d[j] = live_q & ~clr_s;
      end else begin
        dep_d[j] = dep_q[j] & ~clr_s;
      end
    end
  end

  // Tag state and pulse registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      live_q <= ZERO_BRM;
      dep_q  <= {(WIDTH_BRM*WIDTH_BRM){1'b0}};
      kill_q <= ZERO_BRM;
      free_q <= ZERO_BRM;
    end else begin
      live_q <= live_d;
      dep_q  <= dep_d;
      kill_q <= kill_d;
      free_q <= free_d;
    end
  end

  assign o_ready     = ready_s;
  assign o_full      = !ready_s;
  assign o_empty     = (live_q == ZERO_BRM);
  assign o_tag       = tag_s;
  assign o_brmask    = live_q;
  assign o_kill_mask = kill_q;
  assign o_free_mask = free_q;

`ifdef BRTAG_STATS_EN
  localparam logic [WIDTH_CNT-1:0] ONE_CNT = {{(WIDTH_CNT-1){1'b0}}, 1'b1};
  localparam logic [WIDTH_CNT-1:0] MAX_CNT = {WIDTH_CNT{1'b1}};

  logic [WIDTH_CNT-1:0] alloc_cnt_q, alloc_cnt_d;
  logic [WIDTH_CNT-1:0] kill_cnt_q, kill_cnt_d;

  // Saturating event counters.
  always_comb begin
    if (alloc_fire_s && (alloc_cnt_q != MAX_CNT)) begin
      alloc_cnt_d = alloc_cnt_q + ONE_CNT;
    end else begin
      alloc_cnt_d = alloc_cnt_q;
    end
    if (kill_fire_s && (kill_cnt_q != MAX_CNT)) begin
      kill_cnt_d = kill_cnt_q + ONE_CNT;
    end else begin
      kill_cnt_d = kill_cnt_q;
    end
  end

  // Counter registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      alloc_cnt_q <= {WIDTH_CNT{1'b0}};
      kill_cnt_q  <= {WIDTH_CNT{1'b0}};
    end else begin
      alloc_cnt_q <= alloc_cnt_d;
      kill_cnt_q  <= kill_cnt_d;
    end
  end

  assign o_alloc_cnt = alloc_cnt_q;
  assign o_kill_cnt  = kill_cnt_q;
`else
  localparam int unused_width_cnt = WIDTH_CNT;
`endif

endmodule

// File: tb/tb_brtag_alloc.sv
// Scoreboard bench for brtag_alloc: a reference model keeps live tags as an age-ordered
// queue; expectations are queued by the driver and compared by a negedge monitor.
module tb_brtag_alloc;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_alloc = 1'b0;
  logic       i_res_valid = 1'b0;
  logic [3:0] i_res_tag = 4'h0;
  logic       i_res_kill = 1'b0;
  logic       o_ready, o_full, o_empty;
  logic [3:0] o_tag, o_brmask, o_kill_mask, o_free_mask;

  always #5 clk = ~clk;

  brtag_alloc #(.WIDTH_BRM(4), .WIDTH_CNT(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_alloc(i_alloc), .o_ready(o_ready), .o_tag(o_tag),
    .o_brmask(o_brmask), .i_res_valid(i_res_valid), .i_res_tag(i_res_tag),
    .i_res_kill(i_res_kill), .o_kill_mask(o_kill_mask), .o_free_mask(o_free_mask),
    .o_full(o_full), .o_empty(o_empty)
  );

  typedef struct {
    logic [3:0] tag;
    logic [3:0] brmask;
    logic [3:0] kill;
    logic [3:0] free;
    logic       ready;
    logic       full;
    logic       empty;
  } exp_t;

  exp_t       exp_q[$];
  int         order[$];   // live tag indices, oldest first
  logic [3:0] pend_kill = 4'h0;
  logic [3:0] pend_free = 4'h0;
  int         n_checks = 0;
  int         n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] model_live();
    logic [3:0] m = 4'h0;
    for (int p = 0; p < order.size(); p++) m[order[p]] = 1'b1;
    return m;
  endfunction

  function automatic int lowest_free(input logic [3:0] live);
    for (int i = 0; i < 4; i++) if (!live[i]) return i;
    return -1;
  endfunction

  // Monitor: outputs are valid every cycle; compare against queued expectations.
  always @(negedge clk) begin : mon
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("o_tag", o_tag, e.tag);
      chk("o_brmask", o_brmask, e.brmask);
      chk("o_kill_mask", o_kill_mask, e.kill);
      chk("o_free_mask", o_free_mask, e.free);
      chk("o_ready", o_ready, e.ready);
      chk("o_full", o_full, e.full);
      chk("o_empty", o_empty, e.empty);
    end
  end

  task automatic step(input logic a, input logic rv, input logic [3:0] rt, input logic rk);
    exp_t e;
    logic [3:0] live;
    int cand, idx, pos;
    logic killing;
    @(posedge clk);
    #1;
    live    = model_live();
    cand    = lowest_free(live);
    e.tag    = (cand >= 0) ? (4'h1 << cand) : 4'h0;
    e.brmask = live;
    e.kill   = pend_kill;
    e.free   = pend_free;
    e.ready  = (cand >= 0);
    e.full   = (cand < 0);
    e.empty  = (live == 4'h0);
    exp_q.push_back(e);
    i_alloc = a; i_res_valid = rv; i_res_tag = rt; i_res_kill = rk;
    if (rst_n) begin
      pend_kill = 4'h0;
      pend_free = 4'h0;
      killing   = 1'b0;
      idx       = -1;
      if ($countones(rt) == 1) for (int i = 0; i < 4; i++) if (rt[i]) idx = i;
      if (rv && idx >= 0 && live[idx]) begin
        pos = 0;
        for (int p = 0; p < order.size(); p++) if (order[p] == idx) pos = p;
        if (rk) begin
          killing = 1'b1;
          while (order.size() > pos) begin
            pend_kill[order[order.size()-1]] = 1'b1;
            void'(order.pop_back());
          end
        end else begin
          pend_free[idx] = 1'b1;
          order.delete(pos);
        end
      end
      if (a && cand >= 0 && !killing) order.push_back(cand);
    end
  endtask

  initial begin
    logic [3:0] rt;
    int r;
    step(1'b0, 1'b0, 4'h0, 1'b0);
    step(1'b0, 1'b0, 4'h0, 1'b0);
    @(negedge clk); rst_n = 1'b1;

    repeat (4) step(1'b1, 1'b0, 4'h0, 1'b0);
    step(1'b1, 1'b0, 4'h0, 1'b0);
    chk("full_after_4", o_full, 1'b1);
    chk("ready_after_4", o_ready, 1'b0);
    chk("tag_when_full", o_tag, 4'h0);
    step(1'b0, 1'b1, 4'h2, 1'b0);
    chk("alloc_while_full_ignored", o_brmask, 4'hF);
    step(1'b0, 1'b0, 4'h0, 1'b0);
    chk("free_pulse_2", o_free_mask, 4'h2);
    chk("live_after_free", o_brmask, 4'hD);
    step(1'b1, 1'b0, 4'h0, 1'b0);
    chk("realloc_tag_2", o_tag, 4'h2);
    chk("free_pulse_one_cycle", o_free_mask, 4'h0);
    step(1'b0, 1'b1, 4'h1, 1'b1);
    step(1'b0, 1'b0, 4'h0, 1'b0);
    chk("kill_all", o_kill_mask, 4'hF);
    repeat (4) step(1'b1, 1'b0, 4'h0, 1'b0);
    step(1'b0, 1'b1, 4'h2, 1'b1);
    step(1'b0, 1'b0, 4'h0, 1'b0);
    chk("kill_mask_E", o_kill_mask, 4'hE);
    chk("live_after_kill", o_brmask, 4'h1);
    step(1'b1, 1'b0, 4'h0, 1'b0);
    step(1'b1, 1'b1, 4'h1, 1'b1);
    chk("live_before_kill_alloc", o_brmask, 4'h3);
    step(1'b0, 1'b0, 4'h0, 1'b0);
    chk("kill_with_alloc", o_kill_mask, 4'h3);
    chk("alloc_dropped", o_brmask, 4'h0);
    repeat (3) step(1'b1, 1'b0, 4'h0, 1'b0);
    step(1'b0, 1'b0, 4'h0, 1'b0);
    chk("live_7", o_brmask, 4'h7);

    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_brmask", o_brmask, 4'h0);
    chk("rst_empty", o_empty, 1'b1);
    chk("rst_ready", o_ready, 1'b1);
    chk("rst_kill", o_kill_mask, 4'h0);
    chk("rst_free", o_free_mask, 4'h0);
    order.delete();
    pend_kill = 4'h0;
    pend_free = 4'h0;
    step(1'b1, 1'b1, 4'h1, 1'b1);
    step(1'b0, 1'b0, 4'h0, 1'b0);
    @(negedge clk); rst_n = 1'b1;

    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0) rt = 4'h0;
      else if (r == 1) rt = 4'($urandom_range(0, 15));
      else rt = 4'h1 << $urandom_range(0, 3);
      step(1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 9) < 4), rt,
           1'($urandom_range(0, 9) < 3));
    end
    step(1'b0, 1'b0, 4'h0, 1'b0);
    step(1'b0, 1'b0, 4'h0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
